// File: rtl/count_display_mux.sv
// count_display_mux
// Shows a 4-bit counter value (0..15) as two decimal digits on a
// common-anode, time-multiplexed, 2-digit 7-segment display.
// The value is latched once per frame so both digits always come from
// the same value. The anodes are blanked for a few cycles at every
// digit switch to suppress ghosting.
//
// Ports:
//   Clk   in   1  system clock, rising edge
//   Clr   in   1  synchronous active-high reset
//   Q     in   4  value to display, unsigned 0..15
//   En    in   1  display enable (0 = all anodes off, timing keeps running)
//   Seg   out  7  segments, active-low, bit0=a .. bit6=g
//   An    out  2  anodes, active-low, An[0]=ones, An[1]=tens
//   Frame out  1  one-cycle pulse after a new value has been latched
module count_display_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK       = 4,
  parameter bit LZB         = 1'b1
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic [3:0] Q,
  input  logic       En,
  output logic [6:0] Seg,
  output logic [1:0] An,
  output logic       Frame
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST      = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK);

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment pattern for one decimal digit.
  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  logic [CW-1:0] refcnt;
  logic          idx;
  logic [3:0]    v;

  logic          tick;
  logic [3:0]    ones;
  logic [3:0]    tens;
  logic [1:0]    an_next;
  logic [6:0]    seg_next;

  // Slot timing and digit split of the held value.
  always_comb begin
    tick = (refcnt == LAST);
    if (v >= 4'd10) begin
      tens = 4'd1;
      ones = v - 4'd10;
    end else begin
      tens = 4'd0;
      ones = v;
    end
  end

  // Next anode/segment drive from the current slot state.
  always_comb begin
    an_next  = 2'b11;
    seg_next = SEG_BLANK;
    if (!En) begin
      an_next  = 2'b11;
      seg_next = SEG_BLANK;
    end else begin
      // Anodes stay off for the first BLANK cycles of each slot.
      if (refcnt < BLANK_END) begin
        an_next = 2'b11;
      end else if (idx == 1'b0) begin
        an_next = 2'b10;
      end else begin
        an_next = 2'b01;
      end
      if (idx == 1'b0) begin
        seg_next = seg_code(ones);
      end else if (LZB && (v < 4'd10)) begin
        seg_next = SEG_BLANK;
      end else begin
        seg_next = seg_code(tens);
      end
    end
  end

  // Refresh counter, slot index, frame latch and registered outputs.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      refcnt <= '0;
      idx    <= 1'b0;
      v      <= 4'd0;
      An     <= 2'b11;
      Seg    <= SEG_BLANK;
      Frame  <= 1'b0;
    end else begin
      if (tick) begin
        refcnt <= '0;
        idx    <= ~idx;
      end else begin
        refcnt <= refcnt + {{(CW-1){1'b0}}, 1'b1};
      end
      // End of the tens slot closes the frame: take a fresh value.
      if (tick && idx) begin
        v <= Q;
      end
      Frame <= tick & idx;
      An    <= an_next;
      Seg   <= seg_next;
    end
  end

endmodule

// File: tb/tb_count_display_mux.sv
module tb_count_display_mux;

  localparam int R = 8;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] q   = 4'd0;

  logic [6:0] seg1, seg0;
  logic [1:0] an1, an0;
  logic       frame1, frame0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state: edges since the last reset edge, held value.
  int n = 0;
  int v = 0;
  logic [6:0] codes [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  count_display_mux #(.REFRESH_DIV(R), .BLANK(B), .LZB(1'b1)) dut_lzb1 (
    .Clk(clk), .Clr(clr), .Q(q), .En(en),
    .Seg(seg1), .An(an1), .Frame(frame1)
  );

  count_display_mux #(.REFRESH_DIV(R), .BLANK(B), .LZB(1'b0)) dut_lzb0 (
    .Clk(clk), .Clr(clr), .Q(q), .En(en),
    .Seg(seg0), .An(an0), .Frame(frame0)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Apply inputs for one clock edge, advance the model and compare.
  task automatic step(input logic c, input logic e, input logic [3:0] qq);
    logic [1:0] ea;
    logic [6:0] es1, es0;
    logic       ef;
    int rc, id;
    clr = c; en = e; q = qq;
    @(posedge clk);
    cyc++;
    if (c) begin
      n = 0; v = 0;
      ea = 2'b11; es1 = 7'h7F; es0 = 7'h7F; ef = 1'b0;
    end else begin
      rc = n % R;
      id = (n / R) % 2;
      ef = (rc == R - 1) && (id == 1);
      if (!e) begin
        ea = 2'b11; es1 = 7'h7F; es0 = 7'h7F;
      end else begin
        ea = (rc < B) ? 2'b11 : ((id == 0) ? 2'b10 : 2'b01);
        if (id == 0) begin
          es1 = codes[v % 10];
          es0 = codes[v % 10];
        end else begin
          es1 = (v < 10) ? 7'h7F : codes[v / 10];
          es0 = codes[v / 10];
        end
      end
      if (ef) v = int'(qq);
      n++;
    end
    #1;
    check_eq("an_lzb1",    {6'd0, an1},    {6'd0, ea});
    check_eq("an_lzb0",    {6'd0, an0},    {6'd0, ea});
    check_eq("seg_lzb1",   {1'b0, seg1},   {1'b0, es1});
    check_eq("seg_lzb0",   {1'b0, seg0},   {1'b0, es0});
    check_eq("frame_lzb1", {7'd0, frame1}, {7'd0, ef});
    check_eq("frame_lzb0", {7'd0, frame0}, {7'd0, ef});
  endtask

  initial begin
    int first;
    logic [3:0] rq;
    logic re, rc;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'd7);

    // Steady 7; first Frame must come on edge 16 after release.
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 1'b1, 4'd7);
      if (frame1 && first == 0) first = k;
    end
    check_eq("first_frame", 8'(first), 8'd16);

    // Steady 13 then 15.
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 4'd13);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 4'd15);

    // Tearing guard: hold 5, switch to 12 mid tens slot.
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 4'd5);
    while ((n % (2 * R)) != 12) step(1'b0, 1'b1, 4'd5);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 4'd12);

    // Enable dropped mid-slot.
    while ((n % (2 * R)) != 4) step(1'b0, 1'b1, 4'd9);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd9);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'd9);

    // Reset mid-frame, then timing restarts.
    while ((n % (2 * R)) != 11) step(1'b0, 1'b1, 4'd14);
    step(1'b1, 1'b1, 4'd14);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 4'd14);

    // Randomized traffic.
    rq = 4'd0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
      re = ($urandom_range(0, 15) != 0);
      rc = ($urandom_range(0, 199) == 0);
      step(rc, re, rq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
